hazard_ctrl_unit: RTL and testbench



---
 rtl/hazard_ctrl_unit.sv | 126 ++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard control unit for the 5-stage MIPS pipeline. It produces the load-use stall,
// taken-branch flush and memory-freeze enables, and keeps saturating stall and flush counters.
module hazard_ctrl_unit #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int BR_FLUSH   = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ex_bubble,
  output logic              ifid_flush,
  output logic [1:0]        hdu_state,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  // The first bubble or flush cycle is issued from RUN, so the counter only covers the tail.
  localparam logic [2:0] LS_REM = 3'(LOAD_STALL > 1 ? LOAD_STALL - 2 : 0);
  localparam logic [2:0] BF_REM = 3'(BR_FLUSH > 1 ? BR_FLUSH - 2 : 0);

  state_t     state_reg, state_next;
  logic [2:0] rem_reg, rem_next;
  logic       hazard_hit;

  assign hazard_hit = idex_memread && (idex_rt != '0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      rem_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    if (!mem_busy) begin
      if (branch_taken) begin
        if (BR_FLUSH > 1) begin
          state_next = ST_FLUSH;
          rem_next   = BF_REM;
        end else begin
          state_next = ST_RUN;
          rem_next   = '0;
        end
      end else begin
        case (state_reg)
          ST_RUN: begin
            if (hazard_hit && (LOAD_STALL > 1)) begin
              state_next = ST_LSTALL;
              rem_next   = LS_REM;
            end
          end
          ST_LSTALL, ST_FLUSH: begin
            if (rem_reg == '0) begin
              state_next = ST_RUN;
            end else begin
              rem_next = rem_reg - 3'd1;
            end
          end
          default: begin
            state_next = ST_RUN;
            rem_next   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ex_bubble  = 1'b0;
    ifid_flush = 1'b0;
    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ex_bubble  = 1'b1;
      ifid_flush = 1'b1;
    end else if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (branch_taken || (state_reg == ST_FLUSH)) begin
      ex_bubble  = 1'b1;
      ifid_flush = 1'b1;
    end else if ((state_reg == ST_LSTALL) || hazard_hit) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ex_bubble  = 1'b1;
    end
  end

  assign hdu_state = state_reg;

  // Statistics follow the enables actually presented during the cycle that is ending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (ifid_flush && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three parameterisations share one stimulus stream and are
// checked every cycle against a cycle-debt reference model.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       idex_memread = 1'b0;
  logic [4:0] idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
  logic       ifid_uses_rt = 1'b0, branch_taken = 1'b0, mem_busy = 1'b0;

  always #5 clk = ~clk;

  logic [2:0]  pc_w, if_w, bub, fl;
  logic [1:0]  st0, st1, st2;
  logic [15:0] sc0, sc1, fc0, fc1;
  logic [3:0]  sc2, fc2;
  logic [1:0]  st[3];
  logic [15:0] sc[3], fc[3];

  always_comb begin
    st[0] = st0; st[1] = st1; st[2] = st2;
    sc[0] = sc0; sc[1] = sc1; sc[2] = {12'b0, sc2};
    fc[0] = fc0; fc[1] = fc1; fc[2] = {12'b0, fc2};
  end

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(1), .BR_FLUSH(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_w[0]), .ifid_write(if_w[0]), .ex_bubble(bub[0]), .ifid_flush(fl[0]),
    .hdu_state(st0), .stall_count(sc0), .flush_count(fc0));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(3), .BR_FLUSH(2), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_w[1]), .ifid_write(if_w[1]), .ex_bubble(bub[1]), .ifid_flush(fl[1]),
    .hdu_state(st1), .stall_count(sc1), .flush_count(fc1));

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(7), .BR_FLUSH(3), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .idex_memread(idex_memread), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_w[2]), .ifid_write(if_w[2]), .ex_bubble(bub[2]), .ifid_flush(fl[2]),
    .hdu_state(st2), .stall_count(sc2), .flush_count(fc2));

  // Reference model: each instance owes a number of further stall or flush cycles.
  int ls_cfg[3]   = '{1, 3, 7};
  int bf_cfg[3]   = '{1, 2, 3};
  int cmax_cfg[3] = '{65535, 65535, 15};
  int m_stall[3], m_flush[3], m_sc[3], m_fc[3];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
    end
  endtask

  function automatic bit hit();
    return idex_memread && (idex_rt != 0) &&
           ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_stall[i] = 0; m_flush[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  task automatic set_in(input bit mr, input int rt_ex, input int rs, input int rt_id,
                        input bit urt, input bit br, input bit busy);
    idex_memread = mr; idex_rt = 5'(rt_ex); ifid_rs = 5'(rs); ifid_rt = 5'(rt_id);
    ifid_uses_rt = urt; branch_taken = br; mem_busy = busy;
  endtask

  // Check all instances mid-cycle, then advance the model across the next rising edge.
  task automatic cycle();
    bit pw, eb, ifl;
    int s;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      s = (m_flush[i] > 0) ? 2 : ((m_stall[i] > 0) ? 1 : 0);
      if (mem_busy) begin
        pw = 0; eb = 0; ifl = 0;
      end else if (branch_taken || m_flush[i] > 0) begin
        pw = 1; eb = 1; ifl = 1;
      end else if (m_stall[i] > 0 || hit()) begin
        pw = 0; eb = 1; ifl = 0;
      end else begin
        pw = 1; eb = 0; ifl = 0;
      end
      check("pc_write", i, 32'(pc_w[i]), 32'(pw));
      check("ifid_write", i, 32'(if_w[i]), 32'(pw));
      check("ex_bubble", i, 32'(bub[i]), 32'(eb));
      check("ifid_flush", i, 32'(fl[i]), 32'(ifl));
      check("hdu_state", i, 32'(st[i]), 32'(s));
      check("stall_count", i, 32'(sc[i]), 32'(m_sc[i]));
      check("flush_count", i, 32'(fc[i]), 32'(m_fc[i]));
      if (!pw && m_sc[i] < cmax_cfg[i]) m_sc[i]++;
      if (ifl && m_fc[i] < cmax_cfg[i]) m_fc[i]++;
      if (!mem_busy) begin
        if (branch_taken) begin
          m_flush[i] = bf_cfg[i] - 1; m_stall[i] = 0;
        end else if (m_flush[i] > 0) begin
          m_flush[i]--;
        end else if (m_stall[i] > 0) begin
          m_stall[i]--;
        end else if (hit()) begin
          m_stall[i] = ls_cfg[i] - 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Assert reset away from the clock edge and check the forced outputs straight away.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_pc_write", i, 32'(pc_w[i]), 32'd0);
      check("rst_ifid_write", i, 32'(if_w[i]), 32'd0);
      check("rst_ex_bubble", i, 32'(bub[i]), 32'd1);
      check("rst_ifid_flush", i, 32'(fl[i]), 32'd1);
      check("rst_hdu_state", i, 32'(st[i]), 32'd0);
      check("rst_stall_count", i, 32'(sc[i]), 32'd0);
      check("rst_flush_count", i, 32'(fc[i]), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    set_in(0, 0, 0, 0, 0, 0, 0);
    async_reset();
    idle(2);

    // Load-use hit on rs, then the same pattern with $0 as the load target.
    set_in(1, 8, 8, 0, 0, 0, 0); cycle();
    idle(8);
    check("ls_rs_stalls", 0, 32'(sc[0]), 32'd1);
    check("ls_rs_stalls", 1, 32'(sc[1]), 32'd3);
    check("ls_rs_stalls", 2, 32'(sc[2]), 32'd7);
    set_in(1, 0, 0, 0, 0, 0, 0); cycle();
    idle(2);
    check("zero_reg_no_stall", 1, 32'(sc[1]), 32'd3);

    // Hit through rt, honoured only when the instruction reads rt.
    set_in(1, 5, 1, 5, 1, 0, 0); cycle();
    idle(8);
    check("ls_rt_stalls", 1, 32'(sc[1]), 32'd6);
    set_in(1, 5, 1, 5, 0, 0, 0); cycle();
    idle(2);
    check("rt_unused_no_stall", 1, 32'(sc[1]), 32'd6);

    // Taken branch with a coincident hazard that persists one more cycle.
    set_in(1, 8, 8, 0, 0, 1, 0); cycle();
    set_in(1, 8, 8, 0, 0, 0, 0); cycle();
    idle(4);
    check("br_flushes", 0, 32'(fc[0]), 32'd1);
    check("br_flushes", 1, 32'(fc[1]), 32'd2);
    check("br_flushes", 2, 32'(fc[2]), 32'd3);
    check("br_hazard_ignored", 1, 32'(sc[1]), 32'd6);

    // Reset landing in the middle of a load stall.
    set_in(1, 3, 3, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    async_reset();
    idle(1);

    // Memory freeze for four cycles inside a stall.
    set_in(1, 9, 9, 0, 0, 0, 0); cycle();
    idle(1);
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) cycle();
    idle(8);
    check("busy_stall_total", 1, 32'(sc[1]), 32'd7);

    // Long freeze drives the 4-bit counter into saturation.
    set_in(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 22; k++) cycle();
    check("stall_saturate", 2, 32'(sc[2]), 32'd15);
    idle(1);

    // Random traffic with small register numbers so that hits are frequent.
    for (int n = 0; n < 500; n++) begin
      set_in(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      if ($urandom_range(0, 149) == 0) async_reset();
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
